// File: rtl/local_network_interface.sv
// Network interface between a core and a router's local port: credit-based
// packet transmitter (header + N payload flits) and a show-ahead receive FIFO.
module local_network_interface #(
    parameter int RX_DEPTH   = 8,
    parameter int TX_CREDITS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tx_req_i,
    input  logic [7:0]  tx_dest_i,
    input  logic [3:0]  tx_len_i,
    output logic        tx_ack_o,
    input  logic [15:0] tx_data_i,
    input  logic        tx_data_valid_i,
    output logic        tx_data_ready_o,
    output logic        tx_busy_o,
    output logic [15:0] l_data_o,
    output logic        l_valid_o,
    input  logic        l_credit_i,
    input  logic [15:0] l_data_i,
    input  logic        l_valid_i,
    output logic        l_credit_o,
    output logic [15:0] rx_data_o,
    output logic        rx_valid_o,
    output logic        rx_sop_o,
    output logic        rx_eop_o,
    input  logic        rx_ready_i,
    output logic        cred_err_o,
    output logic        rx_ovf_o
);
    localparam int CW = $clog2(TX_CREDITS + 1);
    localparam int AW = $clog2(RX_DEPTH);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HEADER  = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;

    logic [1:0]    state_reg;
    logic [CW-1:0] credit_reg;
    logic [7:0]    dest_reg;
    logic [3:0]    len_reg;
    logic [3:0]    remain_reg;
    logic [15:0]   l_data_reg;
    logic          l_valid_reg;
    logic          cred_err_reg;

    logic credit_avail;
    logic accept_req;
    logic send_header;
    logic send_payload;
    logic flit_sent;

    // Combinational handshakes are gated by reset so every output is low while it is held.
    assign credit_avail    = (credit_reg != '0);
    assign accept_req      = reset && (state_reg == ST_IDLE) && tx_req_i && (tx_len_i != 4'd0);
    assign send_header     = (state_reg == ST_HEADER) && credit_avail;
    assign tx_data_ready_o = reset && (state_reg == ST_PAYLOAD) && credit_avail;
    assign send_payload    = tx_data_ready_o && tx_data_valid_i;
    assign flit_sent       = send_header || send_payload;

    assign tx_ack_o   = accept_req;
    assign tx_busy_o  = reset && (state_reg != ST_IDLE);
    assign l_data_o   = l_data_reg;
    assign l_valid_o  = l_valid_reg;
    assign cred_err_o = cred_err_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            credit_reg   <= CW'(TX_CREDITS);
            dest_reg     <= 8'h00;
            len_reg      <= 4'd0;
            remain_reg   <= 4'd0;
            l_data_reg   <= 16'h0000;
            l_valid_reg  <= 1'b0;
            cred_err_reg <= 1'b0;
        end else begin
            l_valid_reg <= flit_sent;
            case (state_reg)
                ST_IDLE: begin
                    if (accept_req) begin
                        dest_reg  <= tx_dest_i;
                        len_reg   <= tx_len_i;
                        state_reg <= ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (send_header) begin
                        l_data_reg <= {dest_reg, 4'b0000, len_reg};
                        remain_reg <= len_reg;
                        state_reg  <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (send_payload) begin
                        l_data_reg <= tx_data_i;
                        remain_reg <= remain_reg - 4'd1;
                        if (remain_reg == 4'd1) begin
                            state_reg <= ST_IDLE;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase

            // A returned credit and a sent flit in the same cycle cancel out.
            if (flit_sent && !l_credit_i) begin
                credit_reg <= credit_reg - CW'(1);
            end else if (!flit_sent && l_credit_i) begin
                if (credit_reg == CW'(TX_CREDITS)) begin
                    cred_err_reg <= 1'b1;
                end else begin
                    credit_reg <= credit_reg + CW'(1);
                end
            end
        end
    end

    logic [15:0]   mem [RX_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          ovf_reg;
    logic          l_credit_reg;
    logic          expect_hdr_reg;
    logic [3:0]    rx_remain_reg;

    logic        empty;
    logic        full;
    logic        pop;
    logic        push;
    logic [15:0] head;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == (AW+1)'(RX_DEPTH));
    assign head  = mem[rd_ptr_reg];

    assign rx_valid_o = reset && !empty;
    assign pop        = rx_valid_o && rx_ready_i;
    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign push       = reset && l_valid_i && (!full || pop);

    assign rx_data_o  = rx_valid_o ? head : 16'h0000;
    assign rx_sop_o   = rx_valid_o && expect_hdr_reg;
    assign rx_eop_o   = rx_valid_o && !expect_hdr_reg && (rx_remain_reg == 4'd1);
    assign l_credit_o = l_credit_reg;
    assign rx_ovf_o   = ovf_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= l_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            ovf_reg        <= 1'b0;
            l_credit_reg   <= 1'b0;
            expect_hdr_reg <= 1'b1;
            rx_remain_reg  <= 4'd0;
        end else begin
            l_credit_reg <= pop;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            if (push && !pop) begin
                count_reg <= count_reg + (AW+1)'(1);
            end else if (!push && pop) begin
                count_reg <= count_reg - (AW+1)'(1);
            end
            if (l_valid_i && full && !pop) begin
                ovf_reg <= 1'b1;
            end

            // A zero-length header is a complete packet by itself.
            if (pop) begin
                if (expect_hdr_reg) begin
                    if (head[3:0] != 4'd0) begin
                        expect_hdr_reg <= 1'b0;
                        rx_remain_reg  <= head[3:0];
                    end
                end else begin
                    rx_remain_reg <= rx_remain_reg - 4'd1;
                    if (rx_remain_reg == 4'd1) begin
                        expect_hdr_reg <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_local_network_interface.sv
// Directed testbench for local_network_interface: transmit framing and credits,
// receive FIFO ordering, packet tracking, overflow and mid-packet reset.
module tb_local_network_interface;
    logic        clk;
    logic        reset;
    logic        tx_req_i;
    logic [7:0]  tx_dest_i;
    logic [3:0]  tx_len_i;
    logic        tx_ack_o;
    logic [15:0] tx_data_i;
    logic        tx_data_valid_i;
    logic        tx_data_ready_o;
    logic        tx_busy_o;
    logic [15:0] l_data_o;
    logic        l_valid_o;
    logic        l_credit_i;
    logic [15:0] l_data_i;
    logic        l_valid_i;
    logic        l_credit_o;
    logic [15:0] rx_data_o;
    logic        rx_valid_o;
    logic        rx_sop_o;
    logic        rx_eop_o;
    logic        rx_ready_i;
    logic        cred_err_o;
    logic        rx_ovf_o;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    local_network_interface #(.RX_DEPTH(8), .TX_CREDITS(8)) dut (
        .clk(clk), .reset(reset),
        .tx_req_i(tx_req_i), .tx_dest_i(tx_dest_i), .tx_len_i(tx_len_i), .tx_ack_o(tx_ack_o),
        .tx_data_i(tx_data_i), .tx_data_valid_i(tx_data_valid_i), .tx_data_ready_o(tx_data_ready_o),
        .tx_busy_o(tx_busy_o), .l_data_o(l_data_o), .l_valid_o(l_valid_o), .l_credit_i(l_credit_i),
        .l_data_i(l_data_i), .l_valid_i(l_valid_i), .l_credit_o(l_credit_o),
        .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_sop_o(rx_sop_o), .rx_eop_o(rx_eop_o),
        .rx_ready_i(rx_ready_i), .cred_err_o(cred_err_o), .rx_ovf_o(rx_ovf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        reset = 1'b0; tx_req_i = 1'b1; tx_len_i = 4'd3; l_valid_i = 1'b1; l_data_i = 16'h1234;
        tick(); tick();
        chk_cnt++; if (l_data_o !== 16'h0000) $display("FAIL rst_l_data: got %h want 0000", l_data_o); else pass_cnt++;
        chk_cnt++; if (l_valid_o !== 1'b0) $display("FAIL rst_l_valid: got %b want 0", l_valid_o); else pass_cnt++;
        chk_cnt++; if (tx_ack_o !== 1'b0) $display("FAIL rst_ack: got %b want 0", tx_ack_o); else pass_cnt++;
        chk_cnt++; if (tx_busy_o !== 1'b0) $display("FAIL rst_busy: got %b want 0", tx_busy_o); else pass_cnt++;
        chk_cnt++; if (tx_data_ready_o !== 1'b0) $display("FAIL rst_ready: got %b want 0", tx_data_ready_o); else pass_cnt++;
        chk_cnt++; if (rx_valid_o !== 1'b0) $display("FAIL rst_rx_valid: got %b want 0", rx_valid_o); else pass_cnt++;
        chk_cnt++; if (l_credit_o !== 1'b0) $display("FAIL rst_l_credit: got %b want 0", l_credit_o); else pass_cnt++;
        chk_cnt++; if ({cred_err_o, rx_ovf_o} !== 2'b00) $display("FAIL rst_sticky: got %b want 00", {cred_err_o, rx_ovf_o}); else pass_cnt++;
        reset = 1'b1; tx_req_i = 1'b0; tx_len_i = 4'd0; l_valid_i = 1'b0; l_data_i = 16'h0000;
        tick();
        chk_cnt++; if (rx_valid_o !== 1'b0) $display("FAIL rst_no_write: got %b want 0", rx_valid_o); else pass_cnt++;
        $display("[tb] reset test done");
    endtask

    task automatic test_send_basic;
        logic [15:0] pay [3];
        pay[0] = 16'hA0A0; pay[1] = 16'hB1B1; pay[2] = 16'hC2C2;
        tx_req_i = 1'b1; tx_dest_i = 8'h21; tx_len_i = 4'd0;
        #1;
        chk_cnt++; if (tx_ack_o !== 1'b0) $display("FAIL len0_ack: got %b want 0", tx_ack_o); else pass_cnt++;
        tick();
        chk_cnt++; if (tx_busy_o !== 1'b0) $display("FAIL len0_busy: got %b want 0", tx_busy_o); else pass_cnt++;
        tx_len_i = 4'd3;
        #1;
        chk_cnt++; if (tx_ack_o !== 1'b1) $display("FAIL send_ack: got %b want 1", tx_ack_o); else pass_cnt++;
        tick();
        tx_req_i = 1'b0;
        #1;
        chk_cnt++; if (tx_busy_o !== 1'b1) $display("FAIL hdr_busy: got %b want 1", tx_busy_o); else pass_cnt++;
        chk_cnt++; if (tx_data_ready_o !== 1'b0) $display("FAIL hdr_ready: got %b want 0", tx_data_ready_o); else pass_cnt++;
        chk_cnt++; if (l_valid_o !== 1'b0) $display("FAIL hdr_pre_valid: got %b want 0", l_valid_o); else pass_cnt++;
        tick();
        chk_cnt++; if (l_valid_o !== 1'b1 || l_data_o !== 16'h2103) $display("FAIL hdr_flit: got %b/%h want 1/2103", l_valid_o, l_data_o); else pass_cnt++;
        chk_cnt++; if (tx_data_ready_o !== 1'b1) $display("FAIL pay_ready: got %b want 1", tx_data_ready_o); else pass_cnt++;
        tx_data_i = pay[0]; tx_data_valid_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_cnt++; if (l_valid_o !== 1'b1 || l_data_o !== pay[k]) $display("FAIL pay_flit%0d: got %b/%h want 1/%h", k, l_valid_o, l_data_o, pay[k]); else pass_cnt++;
            if (k < 2) tx_data_i = pay[k+1]; else tx_data_valid_i = 1'b0;
        end
        #1;
        chk_cnt++; if (tx_busy_o !== 1'b0 || tx_data_ready_o !== 1'b0) $display("FAIL end_idle: got busy %b ready %b want 0 0", tx_busy_o, tx_data_ready_o); else pass_cnt++;
        tick();
        chk_cnt++; if (l_valid_o !== 1'b0 || l_data_o !== 16'hC2C2) $display("FAIL hold: got %b/%h want 0/c2c2", l_valid_o, l_data_o); else pass_cnt++;
        // Four flits used: four returns bring the count back to full without error.
        for (int k = 0; k < 4; k++) begin
            l_credit_i = 1'b1;
            tick();
        end
        l_credit_i = 1'b0;
        chk_cnt++; if (cred_err_o !== 1'b0) $display("FAIL credit_back_to_8: got err %b want 0", cred_err_o); else pass_cnt++;
        l_credit_i = 1'b1;
        tick();
        l_credit_i = 1'b0;
        chk_cnt++; if (cred_err_o !== 1'b1) $display("FAIL credit_overflow: got err %b want 1", cred_err_o); else pass_cnt++;
        $display("[tb] send dest=21 len=3 done");
    endtask

    task automatic test_credit_stall;
        int sent = 0;
        int idx  = 0;
        logic acc;
        tx_req_i = 1'b1; tx_dest_i = 8'h34; tx_len_i = 4'd9;
        tick();
        tx_req_i = 1'b0; tx_data_valid_i = 1'b1;
        for (int c = 0; c < 15; c++) begin
            tx_data_i = 16'hB000 | 16'(idx);
            #1;
            acc = tx_data_ready_o;
            tick();
            if (l_valid_o) sent++;
            if (acc) idx++;
        end
        chk_cnt++; if (sent != 8) $display("FAIL stall_flits: got %0d want 8", sent); else pass_cnt++;
        chk_cnt++; if (tx_data_ready_o !== 1'b0) $display("FAIL stall_ready: got %b want 0", tx_data_ready_o); else pass_cnt++;
        chk_cnt++; if (l_data_o !== 16'hB006) $display("FAIL stall_last: got %h want b006", l_data_o); else pass_cnt++;
        l_credit_i = 1'b1;
        tick();
        l_credit_i = 1'b0; tx_data_i = 16'hB007;
        #1;
        chk_cnt++; if (tx_data_ready_o !== 1'b1) $display("FAIL credit_ready: got %b want 1", tx_data_ready_o); else pass_cnt++;
        tick();
        chk_cnt++; if (l_valid_o !== 1'b1 || l_data_o !== 16'hB007) $display("FAIL ninth_flit: got %b/%h want 1/b007", l_valid_o, l_data_o); else pass_cnt++;
        chk_cnt++; if (tx_data_ready_o !== 1'b0) $display("FAIL ninth_ready: got %b want 0", tx_data_ready_o); else pass_cnt++;
        l_credit_i = 1'b1;
        tick();
        l_credit_i = 1'b0; tx_data_i = 16'hB008;
        tick();
        tx_data_valid_i = 1'b0;
        chk_cnt++; if (l_data_o !== 16'hB008 || tx_busy_o !== 1'b0) $display("FAIL tenth_flit: got %h busy %b want b008 0", l_data_o, tx_busy_o); else pass_cnt++;
        $display("[tb] send dest=34 len=9 with credit stall done");
    endtask

    task automatic test_credit_coincident;
        tx_req_i = 1'b1; tx_dest_i = 8'h77; tx_len_i = 4'd1;
        tick();
        tx_req_i = 1'b0;
        tick();
        tx_data_i = 16'hD00D; tx_data_valid_i = 1'b1; l_credit_i = 1'b1;
        tick();
        tx_data_valid_i = 1'b0;
        chk_cnt++; if (l_data_o !== 16'hD00D || l_valid_o !== 1'b1) $display("FAIL coinc_flit: got %b/%h want 1/d00d", l_valid_o, l_data_o); else pass_cnt++;
        chk_cnt++; if (cred_err_o !== 1'b0) $display("FAIL coinc_err: got %b want 0", cred_err_o); else pass_cnt++;
        tick();
        chk_cnt++; if (cred_err_o !== 1'b0) $display("FAIL coinc_at7: got %b want 0", cred_err_o); else pass_cnt++;
        tick();
        l_credit_i = 1'b0;
        chk_cnt++; if (cred_err_o !== 1'b1) $display("FAIL coinc_at8: got %b want 1", cred_err_o); else pass_cnt++;
        tick();
        chk_cnt++; if (cred_err_o !== 1'b1) $display("FAIL cred_err_sticky: got %b want 1", cred_err_o); else pass_cnt++;
        $display("[tb] coincident credit done");
    endtask

    task automatic test_back_to_back;
        tx_req_i = 1'b1; tx_dest_i = 8'h55; tx_len_i = 4'd1;
        #1;
        chk_cnt++; if (tx_ack_o !== 1'b1) $display("FAIL b2b_ack1: got %b want 1", tx_ack_o); else pass_cnt++;
        tick();
        tx_req_i = 1'b0;
        tick();
        tx_data_i = 16'h1111; tx_data_valid_i = 1'b1;
        tx_req_i = 1'b1; tx_dest_i = 8'h66;
        #1;
        chk_cnt++; if (tx_ack_o !== 1'b0) $display("FAIL b2b_ack_busy: got %b want 0", tx_ack_o); else pass_cnt++;
        tick();
        tx_data_valid_i = 1'b0;
        #1;
        chk_cnt++; if (tx_ack_o !== 1'b1) $display("FAIL b2b_ack2: got %b want 1", tx_ack_o); else pass_cnt++;
        tick();
        tx_req_i = 1'b0;
        chk_cnt++; if (l_valid_o !== 1'b0) $display("FAIL b2b_gap: got %b want 0", l_valid_o); else pass_cnt++;
        tick();
        chk_cnt++; if (l_data_o !== 16'h6601 || l_valid_o !== 1'b1) $display("FAIL b2b_hdr2: got %b/%h want 1/6601", l_valid_o, l_data_o); else pass_cnt++;
        tx_data_i = 16'h2222; tx_data_valid_i = 1'b1;
        tick();
        tx_data_valid_i = 1'b0;
        chk_cnt++; if (l_data_o !== 16'h2222) $display("FAIL b2b_pay2: got %h want 2222", l_data_o); else pass_cnt++;
        $display("[tb] back-to-back packets done");
    endtask

    task automatic test_rx_basic;
        rx_ready_i = 1'b1; l_valid_i = 1'b1; l_data_i = 16'h1202;
        tick();
        l_data_i = 16'hAAAA;
        chk_cnt++; if (rx_valid_o !== 1'b1 || rx_data_o !== 16'h1202) $display("FAIL rx_hdr: got %b/%h want 1/1202", rx_valid_o, rx_data_o); else pass_cnt++;
        chk_cnt++; if ({rx_sop_o, rx_eop_o, l_credit_o} !== 3'b100) $display("FAIL rx_hdr_flags: got %b want 100", {rx_sop_o, rx_eop_o, l_credit_o}); else pass_cnt++;
        tick();
        l_data_i = 16'hBBBB;
        chk_cnt++; if (rx_data_o !== 16'hAAAA || {rx_sop_o, rx_eop_o, l_credit_o} !== 3'b001) $display("FAIL rx_x: got %h/%b want aaaa/001", rx_data_o, {rx_sop_o, rx_eop_o, l_credit_o}); else pass_cnt++;
        tick();
        l_valid_i = 1'b0;
        chk_cnt++; if (rx_data_o !== 16'hBBBB || {rx_sop_o, rx_eop_o, l_credit_o} !== 3'b011) $display("FAIL rx_y: got %h/%b want bbbb/011", rx_data_o, {rx_sop_o, rx_eop_o, l_credit_o}); else pass_cnt++;
        tick();
        chk_cnt++; if (rx_valid_o !== 1'b0 || l_credit_o !== 1'b1) $display("FAIL rx_drain: got valid %b credit %b want 0 1", rx_valid_o, l_credit_o); else pass_cnt++;
        tick();
        rx_ready_i = 1'b0;
        chk_cnt++; if (l_credit_o !== 1'b0) $display("FAIL rx_credit_end: got %b want 0", l_credit_o); else pass_cnt++;
        $display("[tb] rx packet 1202 done");
    endtask

    task automatic test_rx_zero_len;
        logic [15:0] flits [3];
        flits[0] = 16'h3300; flits[1] = 16'h4401; flits[2] = 16'h5A5A;
        l_valid_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            l_data_i = flits[k];
            tick();
        end
        l_valid_i = 1'b0;
        chk_cnt++; if (rx_data_o !== 16'h3300 || {rx_sop_o, rx_eop_o} !== 2'b10) $display("FAIL zlen_hdr: got %h/%b want 3300/10", rx_data_o, {rx_sop_o, rx_eop_o}); else pass_cnt++;
        rx_ready_i = 1'b1;
        tick();
        chk_cnt++; if (rx_data_o !== 16'h4401 || {rx_sop_o, rx_eop_o} !== 2'b10) $display("FAIL zlen_next_hdr: got %h/%b want 4401/10", rx_data_o, {rx_sop_o, rx_eop_o}); else pass_cnt++;
        tick();
        chk_cnt++; if (rx_data_o !== 16'h5A5A || {rx_sop_o, rx_eop_o} !== 2'b01) $display("FAIL zlen_pay: got %h/%b want 5a5a/01", rx_data_o, {rx_sop_o, rx_eop_o}); else pass_cnt++;
        tick();
        rx_ready_i = 1'b0;
        chk_cnt++; if (rx_valid_o !== 1'b0) $display("FAIL zlen_empty: got %b want 0", rx_valid_o); else pass_cnt++;
        $display("[tb] rx zero-length header done");
    endtask

    task automatic test_rx_overflow;
        int credits = 0;
        l_valid_i = 1'b1;
        for (int k = 0; k < 9; k++) begin
            l_data_i = 16'hC000 | 16'(k);
            tick();
            if (k == 7) begin
                chk_cnt++; if (rx_ovf_o !== 1'b0) $display("FAIL ovf_early: got %b want 0", rx_ovf_o); else pass_cnt++;
            end
        end
        l_valid_i = 1'b0;
        chk_cnt++; if (rx_ovf_o !== 1'b1) $display("FAIL ovf_set: got %b want 1", rx_ovf_o); else pass_cnt++;
        rx_ready_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk_cnt++; if (rx_data_o !== (16'hC000 | 16'(k))) $display("FAIL ovf_pop%0d: got %h want %h", k, rx_data_o, 16'hC000 | 16'(k)); else pass_cnt++;
            tick();
            if (l_credit_o) credits++;
        end
        chk_cnt++; if (credits != 8) $display("FAIL ovf_credits: got %0d want 8", credits); else pass_cnt++;
        chk_cnt++; if (rx_valid_o !== 1'b0) $display("FAIL ovf_dropped: got valid %b want 0", rx_valid_o); else pass_cnt++;
        rx_ready_i = 1'b0; l_valid_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            l_data_i = 16'hE000 | 16'(k);
            tick();
        end
        l_valid_i = 1'b0; rx_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk_cnt++; if (rx_data_o !== (16'hE000 | 16'(k)) || rx_valid_o !== 1'b1) $display("FAIL wrap_pop%0d: got %b/%h want 1/%h", k, rx_valid_o, rx_data_o, 16'hE000 | 16'(k)); else pass_cnt++;
            tick();
        end
        rx_ready_i = 1'b0;
        chk_cnt++; if (rx_valid_o !== 1'b0) $display("FAIL wrap_empty: got %b want 0", rx_valid_o); else pass_cnt++;
        $display("[tb] rx overflow and wrap done");
    endtask

    task automatic test_reset_mid;
        int stray = 0;
        tx_req_i = 1'b1; tx_dest_i = 8'h12; tx_len_i = 4'd5;
        tick();
        tx_req_i = 1'b0;
        tick();
        tx_data_valid_i = 1'b1; tx_data_i = 16'hF000;
        tick();
        tx_data_i = 16'hF001;
        tick();
        tx_data_i = 16'hF002;
        chk_cnt++; if (l_data_o !== 16'hF001) $display("FAIL mid_second: got %h want f001", l_data_o); else pass_cnt++;
        reset = 1'b0;
        tick();
        chk_cnt++; if ({l_valid_o, tx_busy_o, tx_data_ready_o} !== 3'b000) $display("FAIL mid_abort: got %b want 000", {l_valid_o, tx_busy_o, tx_data_ready_o}); else pass_cnt++;
        chk_cnt++; if (l_data_o !== 16'h0000) $display("FAIL mid_data: got %h want 0000", l_data_o); else pass_cnt++;
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (l_valid_o) stray++;
        end
        tx_data_valid_i = 1'b0;
        chk_cnt++; if (stray != 0) $display("FAIL mid_stray: got %0d flits want 0", stray); else pass_cnt++;
        l_credit_i = 1'b1;
        tick();
        l_credit_i = 1'b0;
        chk_cnt++; if (cred_err_o !== 1'b1) $display("FAIL mid_credit8: got err %b want 1", cred_err_o); else pass_cnt++;
        $display("[tb] reset mid-packet done");
    endtask

    initial begin
        reset = 1'b0; tx_req_i = 1'b0; tx_dest_i = 8'h00; tx_len_i = 4'd0;
        tx_data_i = 16'h0000; tx_data_valid_i = 1'b0; l_credit_i = 1'b0;
        l_data_i = 16'h0000; l_valid_i = 1'b0; rx_ready_i = 1'b0;
        test_reset();
        test_send_basic();
        do_reset();
        test_credit_stall();
        do_reset();
        test_credit_coincident();
        do_reset();
        test_back_to_back();
        test_rx_basic();
        test_rx_zero_len();
        test_rx_overflow();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
